// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transceiver: FSM state enums,
// parity-mode codes, oversampling ratio and the baud divider helper.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop} rx_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick: one-cycle pulse every CLK_HZ/(16*BAUD) clocks.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_baud_gen: CLK_HZ/(16*BAUD) must be at least 2");
    end

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_trx_core.sv
// Full-duplex UART core. Define UART_PARITY_EN to honour PARITY (odd/even bit
// sent and checked); otherwise no parity bit exists and rx_parity_err stays 0.
module uart_trx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       hw_clk,
    input  logic       hw_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uarttx,
    input  logic       uartrx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err
);

    localparam int unsigned DIV     = baud_div(CLK_HZ, BAUD);
    localparam int unsigned BIT_CYC = OVERSAMPLE * DIV;
    localparam int unsigned TMR_W   = (BIT_CYC < 2) ? 1 : $clog2(BIT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BIT_CYC - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [3:0]       HALF_LAST = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       FULL_LAST = 4'(OVERSAMPLE - 1);
    localparam logic             PAR_ODD_SEL = (PARITY == PAR_ODD);
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = (PARITY != PAR_NONE);
`else
    localparam bit PAR_EN = 1'b0;
`endif

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
        $error("uart_trx_core: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_trx_core: STOP_BITS must be 1 or 2");
    end

    logic w_tick;

    uart_baud_gen #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_baud (
        .i_clk  (hw_clk),
        .i_rst_n(hw_rst_n),
        .o_tick (w_tick)
    );

    // TX times bits in clocks from acceptance, so every bit is exactly 16 tick periods.
    tx_state_e              r_tx_state, w_tx_state_d;
    logic [TMR_W-1:0]       r_tx_tmr, w_tx_tmr_d;
    logic [2:0]             r_tx_cnt, w_tx_cnt_d;
    logic [DATA_BITS-1:0]   r_tx_shift, w_tx_shift_d;
    logic                   r_tx_par, w_tx_par_d;
    logic                   r_txd, w_txd_d;
    logic                   r_tx_ready, w_tx_ready_d;
    logic                   w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_tmr == TMR_LAST);

    always_ff @(posedge hw_clk) begin
        if (!hw_rst_n) begin
            r_tx_state <= TxIdle;
            r_tx_tmr   <= '0;
            r_tx_cnt   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_d;
            r_tx_tmr   <= w_tx_tmr_d;
            r_tx_cnt   <= w_tx_cnt_d;
            r_tx_shift <= w_tx_shift_d;
            r_tx_par   <= w_tx_par_d;
            r_txd      <= w_txd_d;
            r_tx_ready <= w_tx_ready_d;
        end
    end

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_tmr_d   = r_tx_tmr + TMR_W'(1);
        w_tx_cnt_d   = r_tx_cnt;
        w_tx_shift_d = r_tx_shift;
        w_tx_par_d   = r_tx_par;
        w_txd_d      = r_txd;
        w_tx_ready_d = 1'b0;
        unique case (r_tx_state)
            TxIdle: begin
                w_tx_tmr_d   = '0;
                w_txd_d      = 1'b1;
                w_tx_ready_d = 1'b1;
                if (tx_valid && r_tx_ready) begin
                    w_tx_state_d = TxStart;
                    w_txd_d      = 1'b0;
                    w_tx_ready_d = 1'b0;
                    w_tx_shift_d = tx_data[DATA_BITS-1:0];
                    w_tx_par_d   = (^tx_data[DATA_BITS-1:0]) ^ PAR_ODD_SEL;
                end
            end
            TxStart: begin
                if (w_tx_bit_end) begin
                    w_tx_state_d = TxData;
                    w_tx_tmr_d   = '0;
                    w_tx_cnt_d   = '0;
                    w_txd_d      = r_tx_shift[0];
                end
            end
            TxData: begin
                if (w_tx_bit_end) begin
                    w_tx_tmr_d = '0;
                    if (r_tx_cnt == DATA_LAST) begin
                        w_tx_cnt_d   = '0;
                        w_tx_state_d = PAR_EN ? TxPar : TxStop;
                        w_txd_d      = PAR_EN ? r_tx_par : 1'b1;
                    end else begin
                        w_tx_cnt_d   = r_tx_cnt + 3'd1;
                        w_tx_shift_d = r_tx_shift >> 1;
                        w_txd_d      = r_tx_shift[1];
                    end
                end
            end
            TxPar: begin
                if (w_tx_bit_end) begin
                    w_tx_state_d = TxStop;
                    w_tx_tmr_d   = '0;
                    w_tx_cnt_d   = '0;
                    w_txd_d      = 1'b1;
                end
            end
            TxStop: begin
                if (w_tx_bit_end) begin
                    w_tx_tmr_d = '0;
                    if (r_tx_cnt == STOP_LAST) begin
                        w_tx_state_d = TxIdle;
                        w_tx_ready_d = 1'b1;
                    end else begin
                        w_tx_cnt_d = r_tx_cnt + 3'd1;
                    end
                end
            end
            default: w_tx_state_d = TxIdle;
        endcase
    end

    assign tx_ready = r_tx_ready;
    assign uarttx   = r_txd;

    rx_state_e              r_rx_state, w_rx_state_d;
    logic                   r_rx_meta, r_rx_sync;
    logic [3:0]             r_rx_tcnt, w_rx_tcnt_d;
    logic [2:0]             r_rx_idx, w_rx_idx_d;
    logic [DATA_BITS-1:0]   r_rx_shift, w_rx_shift_d;
    logic                   r_rx_ppend, w_rx_ppend_d;
    logic [7:0]             r_rx_data, w_rx_data_d;
    logic                   r_rx_valid, w_rx_valid_d;
    logic                   r_rx_ferr, w_rx_ferr_d;
    logic                   r_rx_perr, w_rx_perr_d;

    always_ff @(posedge hw_clk) begin
        if (!hw_rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= RxIdle;
            r_rx_tcnt  <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_ppend <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_perr  <= 1'b0;
        end else begin
            r_rx_meta  <= uartrx;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_state_d;
            r_rx_tcnt  <= w_rx_tcnt_d;
            r_rx_idx   <= w_rx_idx_d;
            r_rx_shift <= w_rx_shift_d;
            r_rx_ppend <= w_rx_ppend_d;
            r_rx_data  <= w_rx_data_d;
            r_rx_valid <= w_rx_valid_d;
            r_rx_ferr  <= w_rx_ferr_d;
            r_rx_perr  <= w_rx_perr_d;
        end
    end

    always_comb begin
        w_rx_state_d = r_rx_state;
        w_rx_tcnt_d  = r_rx_tcnt;
        w_rx_idx_d   = r_rx_idx;
        w_rx_shift_d = r_rx_shift;
        w_rx_ppend_d = r_rx_ppend;
        w_rx_data_d  = r_rx_data;
        w_rx_valid_d = 1'b0;
        w_rx_ferr_d  = r_rx_ferr;
        w_rx_perr_d  = r_rx_perr;
        if (w_tick) begin
            w_rx_tcnt_d = r_rx_tcnt + 4'd1;
            unique case (r_rx_state)
                RxIdle: begin
                    w_rx_tcnt_d = '0;
                    if (!r_rx_sync) w_rx_state_d = RxStart;
                end
                RxStart: begin
                    if (r_rx_tcnt == HALF_LAST) begin
                        // Line back high at mid start bit: a glitch, not a frame.
                        w_rx_tcnt_d  = '0;
                        w_rx_idx_d   = '0;
                        w_rx_state_d = r_rx_sync ? RxIdle : RxData;
                    end
                end
                RxData: begin
                    if (r_rx_tcnt == FULL_LAST) begin
                        w_rx_tcnt_d  = '0;
                        w_rx_shift_d = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx == DATA_LAST) begin
                            w_rx_state_d = PAR_EN ? RxPar : RxStop;
                        end else begin
                            w_rx_idx_d = r_rx_idx + 3'd1;
                        end
                    end
                end
                RxPar: begin
                    if (r_rx_tcnt == FULL_LAST) begin
                        w_rx_tcnt_d  = '0;
                        w_rx_ppend_d = (^{r_rx_shift, r_rx_sync}) ^ PAR_ODD_SEL;
                        w_rx_state_d = RxStop;
                    end
                end
                RxStop: begin
                    if (r_rx_tcnt == FULL_LAST) begin
                        w_rx_tcnt_d  = '0;
                        w_rx_valid_d = 1'b1;
                        w_rx_data_d  = 8'(r_rx_shift);
                        w_rx_ferr_d  = !r_rx_sync;
                        w_rx_perr_d  = PAR_EN && r_rx_ppend;
                        w_rx_state_d = RxIdle;
                    end
                end
                default: w_rx_state_d = RxIdle;
            endcase
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_frame_err  = r_rx_ferr;
    assign rx_parity_err = r_rx_perr;

endmodule

// File: doc/uart_trx_core.md
UART_TRX_CORE -- requirements
Module: uart_trx_core

Interface
REQ-001 Parameter CLK_HZ, 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, line rate in bit/s.
REQ-003 Parameter DATA_BITS, 8, payload width, legal range 5..8.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, 1, stop bits transmitted, 1 or 2.
REQ-006 Port hw_clk  in  1  single system clock; all logic on its rising edge.
REQ-007 Port hw_rst_n  in  1  synchronous active-low reset.
REQ-008 Port tx_data  in  8  byte to send; bits above DATA_BITS-1 ignored.
REQ-009 Port tx_valid  in  1  transmit request.
REQ-010 Port tx_ready  out  1  transmitter can accept a byte.
REQ-011 Port uarttx  out  1  serial output, idle high.
REQ-012 Port uartrx  in  1  asynchronous serial input.
REQ-013 Port rx_data  out  8  received byte, zero-extended above DATA_BITS.
REQ-014 Port rx_valid  out  1  one-cycle pulse when a byte is received.
REQ-015 Port rx_frame_err  out  1  stop bit sampled low; valid with rx_valid.
REQ-016 Port rx_parity_err  out  1  parity mismatch; valid with rx_valid.

Function
REQ-017 Baud tick SHALL pulse for one hw_clk cycle every DIV cycles, DIV = CLK_HZ/(16*BAUD) truncated (78 at defaults); one bit = 16 ticks; DIV < 2 SHALL be an elaboration error.
REQ-018 A byte SHALL be accepted on a cycle where tx_valid && tx_ready; tx_data is latched that cycle and tx_ready drops the next cycle.
REQ-019 The TX FSM SHALL use states IDLE, START, DATA, PAR, STOP: start bit 0, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits of 1, each bit exactly 16 ticks.
REQ-020 The TX bit timer SHALL restart at acceptance, so that the start bit begins the cycle after acceptance.
REQ-021 tx_ready SHALL rise the cycle after the last stop bit ends; if tx_valid is then high, the next start bit follows with no idle gap.
REQ-022 uartrx SHALL pass through a two-flop synchroniser before any use.
REQ-023 The RX FSM SHALL use states IDLE, START, DATA, PAR, STOP; IDLE moves to START on the first tick sampling low.
REQ-024 START SHALL resample after 8 ticks; if the line is high, the FSM returns to IDLE with no output (glitch reject).
REQ-025 Data, parity and stop bits SHALL each be sampled once, 16 ticks after the previous sample (mid-bit); only the first stop bit is checked.
REQ-026 At the stop-bit sample, rx_valid SHALL pulse for one cycle, with rx_data and both error flags valid that cycle and held until the next pulse; the FSM returns to IDLE.
REQ-027 rx_valid SHALL pulse even when an error flag is set.
REQ-028 RX has no backpressure; a new frame may start on the tick after STOP.
REQ-029 TX and RX SHALL operate independently and concurrently, sharing only the baud tick.

Reset
REQ-030 While hw_rst_n is low at a clock edge: uarttx=1, tx_ready=0, rx_valid=0, rx_data=0, both error flags 0, both FSMs IDLE, baud counter 0.
REQ-031 tx_ready SHALL be 1 on the first cycle after hw_rst_n is high.
REQ-032 Reset mid-frame SHALL abandon both frames; no rx_valid is produced for the abandoned frame.

Configuration
REQ-033 Macro UART_PARITY_EN defined: PARITY is honoured and the PAR states exist.
REQ-034 Macro UART_PARITY_EN undefined: PARITY is ignored, no parity bit is sent or expected, and rx_parity_err is tied 0.

Structure
REQ-035 Package uart_pkg SHALL hold the TX/RX state enums, the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and OVERSAMPLE=16.
REQ-036 Sub-module uart_baud_gen (CLK_HZ, BAUD -> tick) SHALL hold the divider.

Verification
REQ-037 Defaults, send 0x46 -> uarttx bits 0,0,1,1,0,0,0,1,0,1, each 1248 clocks; tx_ready low for 12480 clocks.
REQ-038 PARITY=2 with UART_PARITY_EN, send 0x46 -> parity bit 1; PARITY=1 -> parity bit 0.
REQ-039 Loop uarttx to uartrx, send 0x46 then 0xA5 back-to-back -> two rx_valid pulses with 0x46 and 0xA5, all error flags 0.
REQ-040 Drive a frame with 0x3C and the stop bit low -> rx_valid with rx_data=0x3C, rx_frame_err=1.
REQ-041 Low pulse of 300 clocks on uartrx -> no rx_valid; a following 0x55 frame is received correctly.
REQ-042 Assert hw_rst_n low mid-DATA for 1 cycle -> uarttx=1 the next cycle, no rx_valid, tx_ready=1 the cycle after release.
